wb_io_timeout: RTL and testbench

//  Bus-watchdog stage inserted between the AXI-to-Wishbone bridge (master) and the wb_io master port of the IO interconnect.

---
 rtl/wb_io_timeout.sv | 154 +++++++++++++++
 tb/tb_wb_io_timeout.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_io_timeout.sv
// wb_io_timeout: Wishbone bus watchdog between the AXI-to-Wishbone bridge and
// the wb_io master port of the IO interconnect.
//
// All Wishbone signals pass straight through with zero added latency. If a
// request (cyc & stb) waits TIMEOUT_CYCLES cycles in WAIT without ack/err/rty,
// the block spends one ABORT cycle that drops the slave-side cyc/stb and
// returns err to the master. The first err therefore appears
// TIMEOUT_CYCLES+1 cycles after stb rises.
//
// Ports:
//   wb_clk_i, wb_rst_n_i   clock, asynchronous active-low reset
//   wbm_*_i / wbm_*_o      upstream master side (bridge)
//   wbs_*_o / wbs_*_i      downstream slave side (interconnect wb_io port)
//   timeout_o              high during the ABORT cycle
//   tmo_clr_i, tmo_adr_o, tmo_cnt_o
//                          timeout capture registers, present only when the
//                          WB_TIMEOUT_CAPTURE_EN macro is defined
module wb_io_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] wbm_adr_i,
    input  logic [31:0] wbm_dat_i,
    input  logic [3:0]  wbm_sel_i,
    input  logic        wbm_we_i,
    input  logic        wbm_cyc_i,
    input  logic        wbm_stb_i,
    input  logic [2:0]  wbm_cti_i,
    input  logic [1:0]  wbm_bte_i,
    output logic [31:0] wbm_dat_o,
    output logic        wbm_ack_o,
    output logic        wbm_err_o,
    output logic        wbm_rty_o,
    output logic [31:0] wbs_adr_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  wbs_sel_o,
    output logic        wbs_we_o,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic [2:0]  wbs_cti_o,
    output logic [1:0]  wbs_bte_o,
    input  logic [31:0] wbs_dat_i,
    input  logic        wbs_ack_i,
    input  logic        wbs_err_i,
    input  logic        wbs_rty_i,
`ifdef WB_TIMEOUT_CAPTURE_EN
    output logic        timeout_o,
    input  logic        tmo_clr_i,
    output logic [31:0] tmo_adr_o,
    output logic [7:0]  tmo_cnt_o
`else
    output logic        timeout_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             req, resp, aborting;

    assign req      = wbm_cyc_i & wbm_stb_i;
    assign resp     = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign aborting = (state == ABORT);

    // State and wait-counter registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state; cnt counts cycles spent in WAIT, a response always wins over the terminal count
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        case (state)
            IDLE: begin
                if (req && !resp) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (resp || !req) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = ABORT;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ABORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pass-through, overridden only during the ABORT cycle
    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_sel_o = wbm_sel_i;
    assign wbs_we_o  = wbm_we_i;
    assign wbs_cti_o = wbm_cti_i;
    assign wbs_bte_o = wbm_bte_i;
    assign wbs_cyc_o = wbm_cyc_i & ~aborting;
    assign wbs_stb_o = wbm_stb_i & ~aborting;

    assign wbm_dat_o = aborting ? 32'h0 : wbs_dat_i;
    assign wbm_ack_o = wbs_ack_i & ~aborting;
    assign wbm_err_o = wbs_err_i | aborting;
    assign wbm_rty_o = wbs_rty_i & ~aborting;

    assign timeout_o = aborting;

`ifdef WB_TIMEOUT_CAPTURE_EN
    logic abort_entry;

    assign abort_entry = (state == WAIT) && (state_next == ABORT);

    // Capture of the last timed-out address and a saturating timeout count; a new capture beats clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tmo_adr_o <= 32'h0;
            tmo_cnt_o <= 8'h0;
        end else if (abort_entry) begin
            tmo_adr_o <= wbm_adr_i;
            if (tmo_clr_i) begin
                tmo_cnt_o <= 8'd1;
            end else if (tmo_cnt_o != 8'hFF) begin
                tmo_cnt_o <= tmo_cnt_o + 8'd1;
            end
        end else if (tmo_clr_i) begin
            tmo_adr_o <= 32'h0;
            tmo_cnt_o <= 8'h0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_io_timeout.sv
// tb_wb_io_timeout: randomized bench for wb_io_timeout (TIMEOUT_CYCLES=16)
// against a request-age reference model. Builds with or without
// WB_TIMEOUT_CAPTURE_EN.
module tb_wb_io_timeout;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m_adr = '0, m_dat = '0, s_dat = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
    logic [2:0]  m_cti = '0;
    logic [1:0]  m_bte = '0;
    logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

    logic [31:0] wbm_dat_o, wbs_adr_o, wbs_dat_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;
    logic        timeout_o;
`ifdef WB_TIMEOUT_CAPTURE_EN
    logic        tmo_clr = 1'b0;
    logic [31:0] tmo_adr_o;
    logic [7:0]  tmo_cnt_o;
    logic [31:0] ref_tadr = '0;
    int          ref_tcnt = 0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model: number of consecutive earlier cycles with req pending and no response
    int   run = 0;
    logic exp_abort;

    always #5 clk = ~clk;

    wb_io_timeout #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbm_adr_i  (m_adr),
        .wbm_dat_i  (m_dat),
        .wbm_sel_i  (m_sel),
        .wbm_we_i   (m_we),
        .wbm_cyc_i  (m_cyc),
        .wbm_stb_i  (m_stb),
        .wbm_cti_i  (m_cti),
        .wbm_bte_i  (m_bte),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_ack_o  (wbm_ack_o),
        .wbm_err_o  (wbm_err_o),
        .wbm_rty_o  (wbm_rty_o),
        .wbs_adr_o  (wbs_adr_o),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_sel_o  (wbs_sel_o),
        .wbs_we_o   (wbs_we_o),
        .wbs_cyc_o  (wbs_cyc_o),
        .wbs_stb_o  (wbs_stb_o),
        .wbs_cti_o  (wbs_cti_o),
        .wbs_bte_o  (wbs_bte_o),
        .wbs_dat_i  (s_dat),
        .wbs_ack_i  (s_ack),
        .wbs_err_i  (s_err),
        .wbs_rty_i  (s_rty),
`ifdef WB_TIMEOUT_CAPTURE_EN
        .timeout_o  (timeout_o),
        .tmo_clr_i  (tmo_clr),
        .tmo_adr_o  (tmo_adr_o),
        .tmo_cnt_o  (tmo_cnt_o)
`else
        .timeout_o  (timeout_o)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check one cycle with inputs already applied, then advance the model across the clock edge
    task automatic step();
        logic req, resp;
        int   run_next;
        #1;
        req       = m_cyc & m_stb;
        resp      = s_ack | s_err | s_rty;
        exp_abort = rst_n && (run == T + 1);
        check("wbs_fwd", {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o},
              {m_adr, m_dat, m_sel, m_we, m_cyc & ~exp_abort, m_stb & ~exp_abort, m_cti, m_bte});
        check("wbm_dat", wbm_dat_o, exp_abort ? 32'h0 : s_dat);
        check("wbm_rsp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, exp_abort ? 3'b010 : {s_ack, s_err, s_rty});
        check("timeout", timeout_o, exp_abort);
`ifdef WB_TIMEOUT_CAPTURE_EN
        check("tmo_adr", tmo_adr_o, ref_tadr);
        check("tmo_cnt", tmo_cnt_o, 8'(ref_tcnt));
`endif
        if (!rst_n) begin
            run = 0;
`ifdef WB_TIMEOUT_CAPTURE_EN
            ref_tadr = '0;
            ref_tcnt = 0;
`endif
        end else begin
            run_next = exp_abort ? 0 : ((req && !resp) ? run + 1 : 0);
`ifdef WB_TIMEOUT_CAPTURE_EN
            if (run_next == T + 1) begin
                ref_tadr = m_adr;
                ref_tcnt = tmo_clr ? 1 : ((ref_tcnt < 255) ? ref_tcnt + 1 : 255);
            end else if (tmo_clr) begin
                ref_tadr = '0;
                ref_tcnt = 0;
            end
`endif
            run = run_next;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r <= 4) return int'($urandom_range(1, T - 1));
        if (r == 5) return T;
        if (r == 6) return T + 1;
        return 40;
    endfunction

    initial begin
        int   age, lat, kind, wd, beats;
        logic active, drop;
        active = 1'b0;
        age = 0; lat = 0; kind = 0; wd = 255; beats = 0;

        // Reset: pass-through still active, no timeout
        @(posedge clk); #1;
        m_adr = 32'h0000_0ABC; m_cyc = 1'b1; m_stb = 1'b1; s_err = 1'b1; s_dat = 32'h1234_5678;
        step();
        m_cyc = 1'b0; m_stb = 1'b0; s_err = 1'b0;
        step();
        rst_n = 1'b1;

        // Same-cycle ack read
        m_adr = 32'h0000_1040; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
        s_ack = 1'b1; s_dat = 32'hCAFE_F00D;
        step();
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = 1'b0;
        step();

        // Write acked 15 cycles after stb, then silent read that times out
        m_adr = 32'h0000_1200; m_we = 1'b1; m_cyc = 1'b1; m_stb = 1'b1;
        for (int i = 0; i <= 15; i++) begin
            s_ack = (i == 15);
            step();
        end
        s_ack = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        step();
        m_adr = 32'h0000_4000; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        for (int i = 0; i <= T + 1; i++) begin
            s_ack = (i == T + 1);
            step();
        end
        s_ack = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        step();

        // Reset pulse in the middle of a pending read
        m_adr = 32'h0000_5000; m_cyc = 1'b1; m_stb = 1'b1;
        for (int i = 0; i < 11; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        m_cyc = 1'b0; m_stb = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!active && $urandom_range(0, 2) != 0) begin
                active = 1'b1;
                age    = 0;
                m_adr  = $urandom;
                m_dat  = $urandom;
                m_sel  = 4'($urandom);
                m_we   = 1'($urandom);
                m_bte  = 2'($urandom);
                m_cti  = ($urandom_range(0, 3) == 0) ? 3'b010 : 3'b000;
                beats  = (m_cti == 3'b010) ? int'($urandom_range(1, 3)) : 0;
                lat    = pick_lat();
                kind   = int'($urandom_range(0, 3));
                wd     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, T + 2)) : 255;
            end
            drop  = active && (age == wd);
            m_stb = active && !drop;
            m_cyc = m_stb ? 1'b1 : 1'($urandom_range(0, 3) == 0);
            s_dat = $urandom;
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            if (m_stb && age == lat) begin
                s_ack = (kind <= 1);
                s_err = (kind == 2);
                s_rty = (kind == 3);
            end else if (!active && $urandom_range(0, 24) == 0) begin
                s_ack = 1'b1;
            end
`ifdef WB_TIMEOUT_CAPTURE_EN
            tmo_clr = ($urandom_range(0, 40) == 0);
`endif
            step();
            if (drop) begin
                active = 1'b0;
            end else if (active) begin
                if (exp_abort) begin
                    active = 1'b0;
                end else if (s_ack | s_err | s_rty) begin
                    if (s_ack && beats > 0) begin
                        beats--;
                        age   = 0;
                        lat   = pick_lat();
                        m_adr = m_adr + 32'd4;
                    end else begin
                        active = 1'b0;
                    end
                end else begin
                    age++;
                end
            end
        end

        // 300+ back-to-back timeouts with a silent slave, then clear
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
`ifdef WB_TIMEOUT_CAPTURE_EN
        tmo_clr = 1'b0;
`endif
        m_adr = 32'h0000_7F00; m_cyc = 1'b1; m_stb = 1'b1;
        for (int i = 0; i < 302 * (T + 2); i++) step();
        m_cyc = 1'b0; m_stb = 1'b0;
        step();
        step();
`ifdef WB_TIMEOUT_CAPTURE_EN
        check("tmo_sat", tmo_cnt_o, 8'hFF);
        tmo_clr = 1'b1;
        step();
        tmo_clr = 1'b0;
        step();
        check("tmo_clr", {tmo_adr_o, tmo_cnt_o}, 40'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
